// File: rtl/breakout_game_ctrl.sv
// Game-level controller for breakout: runs the newgame/play/newball/over flow,
// keeps the BCD score and remaining balls, and packs the 7-segment display word.
module breakout_game_ctrl #(
  parameter logic [1:0]  BALLS     = 2'd3,
  parameter logic [27:0] WAIT_CYC  = 28'd200_000_000,
  parameter logic [4:0]  START_KEY = 5'h10
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [4:0]  key_code,
  input  logic        key_ready,
  input  logic        hit,
  input  logic        miss,
  output logic [1:0]  state,
  output logic        gra_still,
  output logic [15:0] score_bcd,
  output logic [1:0]  balls_left,
  output logic [31:0] seg_data
);

  typedef enum logic [1:0] {
    NEWGAME = 2'b00,
    PLAY    = 2'b01,
    NEWBALL = 2'b10,
    OVER    = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] score_q, score_d;
  logic [1:0]  balls_q, balls_d;
  logic [27:0] timer_q, timer_d;
  logic        prev_ready, prev_hit, prev_miss;
  logic        start, hit_e, miss_e;

  assign start  = key_ready & ~prev_ready & (key_code == START_KEY);
  assign hit_e  = hit & ~prev_hit;
  assign miss_e = miss & ~prev_miss;

  // Four-digit BCD increment with ripple carry; 9999 saturates.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    if (v != 16'h9999) begin
      for (int i = 0; i < 4; i++) begin
        if (carry) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    // NOTE: every signal gets a default first so no path through the case infers a latch.
    state_d = state_q;
    score_d = score_q;
    balls_d = balls_q;
    timer_d = timer_q;
    case (state_q)
      NEWGAME: begin
        if (start) begin
          score_d = 16'h0000;
          balls_d = BALLS;
          state_d = PLAY;
        end
      end
      PLAY: begin
        if (hit_e) score_d = bcd_inc(score_q);
        if (miss_e) begin
          timer_d = 28'd0;
          if (balls_q > 2'd1) begin
            balls_d = balls_q - 2'd1;
            state_d = NEWBALL;
          end else begin
            balls_d = 2'd0;
            state_d = OVER;
          end
        end
      end
      NEWBALL: begin
        if (timer_q == WAIT_CYC - 28'd1) begin
          timer_d = 28'd0;
          state_d = PLAY;
        end else begin
          timer_d = timer_q + 28'd1;
        end
      end
      OVER: begin
        // A start before the pause expires is simply dropped, not remembered.
        if (timer_q != WAIT_CYC - 28'd1) timer_d = timer_q + 28'd1;
        else if (start)                  state_d = NEWGAME;
      end
      default: state_d = NEWGAME;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= NEWGAME;
      score_q    <= 16'h0000;
      balls_q    <= BALLS;
      timer_q    <= 28'd0;
      prev_ready <= 1'b0;
      prev_hit   <= 1'b0;
      prev_miss  <= 1'b0;
      gra_still  <= 1'b1;
      seg_data   <= {16'h0000, 14'h0000, BALLS};
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      score_q    <= score_d;
      balls_q    <= balls_d;
      timer_q    <= timer_d;
      prev_ready <= key_ready;
      prev_hit   <= hit;
      prev_miss  <= miss;
      gra_still  <= (state_d != PLAY);
      // Built from the registered values, so the display trails them by a cycle.
      seg_data   <= {score_q, 12'h000, 2'b00, balls_q};
    end
  end

  assign state      = state_q;
  assign score_bcd  = score_q;
  assign balls_left = balls_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Scoreboard bench for breakout_game_ctrl with a short pause (WAIT_CYC=8)
// and three balls; expectations are queued with stimulus and drained on sampling.
module tb_breakout_game_ctrl;

  localparam logic [27:0] WAIT_CYC = 28'd8;
  localparam logic [1:0]  BALLS    = 2'd3;

  logic        clk = 1'b0;
  logic        rstn;
  logic [4:0]  key_code;
  logic        key_ready;
  logic        hit;
  logic        miss;
  logic [1:0]  state;
  logic        gra_still;
  logic [15:0] score_bcd;
  logic [1:0]  balls_left;
  logic [31:0] seg_data;

  breakout_game_ctrl #(
    .BALLS     (BALLS),
    .WAIT_CYC  (WAIT_CYC),
    .START_KEY (5'h10)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .hit        (hit),
    .miss       (miss),
    .state      (state),
    .gra_still  (gra_still),
    .score_bcd  (score_bcd),
    .balls_left (balls_left),
    .seg_data   (seg_data)
  );

  always #5 clk = ~clk;

  typedef enum int {F_STATE, F_STILL, F_SCORE, F_BALLS, F_SEG} field_e;
  typedef struct {
    string       tag;
    field_e      field;
    logic [31:0] value;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   model_score = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_val(input string tag, input field_e f, input logic [31:0] v);
    exp_t e;
    e.tag = tag; e.field = f; e.value = v;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.field)
        F_STATE: obs = {30'd0, state};
        F_STILL: obs = {31'd0, gra_still};
        F_SCORE: obs = {16'd0, score_bcd};
        F_BALLS: obs = {30'd0, balls_left};
        default: obs = seg_data;
      endcase
      check(e.tag, obs, e.value);
    end
  endtask

  function automatic logic [31:0] to_bcd(input int n);
    return {16'd0, 4'(n / 1000 % 10), 4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_all(input string tag, input int st, input int still,
                            input int score, input int balls);
    expect_val({tag, "_state"}, F_STATE, 32'(st));
    expect_val({tag, "_still"}, F_STILL, 32'(still));
    expect_val({tag, "_score"}, F_SCORE, to_bcd(score));
    expect_val({tag, "_balls"}, F_BALLS, 32'(balls));
  endtask

  task automatic press(input logic [4:0] code);
    key_code  = code;
    key_ready = 1'b1;
    tick(1);
  endtask

  task automatic release_key();
    key_ready = 1'b0;
    tick(1);
  endtask

  task automatic hit_pulse(input int hold);
    hit = 1'b1;
    tick(hold);
    hit = 1'b0;
    tick(1);
    if (model_score < 9999) model_score++;
  endtask

  initial begin
    rstn = 1'b0; key_code = 5'h00; key_ready = 1'b0; hit = 1'b0; miss = 1'b0;
    #23;
    expect_all("reset", 0, 1, 0, 3);
    expect_val("reset_seg", F_SEG, 32'h0000_0003);
    drain();
    rstn = 1'b1;
    tick(2);

    // A non-start key leaves the game idle.
    press(5'h05);
    expect_val("other_key_state", F_STATE, 32'd0);
    drain();
    release_key();

    press(5'h10);
    expect_all("start", 1, 0, 0, 3);
    drain();
    key_ready = 1'b1;
    tick(3);
    key_ready = 1'b0;
    expect_val("start_held_state", F_STATE, 32'd1);
    drain();
    tick(1);

    for (int i = 0; i < 12; i++) hit_pulse(3);
    expect_val("twelve_hits", F_SCORE, to_bcd(12));
    expect_val("twelve_seg", F_SEG, {16'h0012, 14'h0, 2'd3});
    drain();

    // First miss: NEWBALL for exactly WAIT_CYC cycles, hits ignored.
    miss = 1'b1;
    tick(1);
    miss = 1'b0;
    expect_all("miss1", 2, 1, 12, 2);
    drain();
    hit = 1'b1;
    tick(1);
    hit = 1'b0;
    tick(6);
    expect_val("newball_hold", F_STATE, 32'd2);
    drain();
    tick(1);
    expect_all("newball_done", 1, 0, 12, 2);
    drain();

    miss = 1'b1;
    tick(1);
    miss = 1'b0;
    expect_all("miss2", 2, 1, 12, 1);
    drain();
    tick(8);
    expect_val("miss2_play", F_STATE, 32'd1);
    drain();

    // Simultaneous hit and last miss.
    hit = 1'b1; miss = 1'b1;
    tick(1);
    hit = 1'b0; miss = 1'b0;
    model_score++;
    expect_all("last_ball", 3, 1, 13, 0);
    drain();
    tick(1);
    press(5'h10);
    expect_val("early_start", F_STATE, 32'd3);
    drain();
    release_key();
    tick(6);
    expect_val("not_queued", F_STATE, 32'd3);
    drain();
    press(5'h10);
    expect_all("over_exit", 0, 1, 13, 0);
    drain();
    release_key();
    press(5'h10);
    expect_all("restart", 1, 0, 0, 3);
    drain();
    release_key();
    model_score = 0;

    while (model_score < 999) hit_pulse(1);
    expect_val("score_0999", F_SCORE, to_bcd(999));
    drain();
    hit_pulse(1);
    expect_val("score_1000", F_SCORE, 32'h1000);
    drain();
    while (model_score < 9999) hit_pulse(1);
    expect_val("score_9999", F_SCORE, 32'h9999);
    drain();
    hit_pulse(1);
    expect_val("score_sat", F_SCORE, 32'h9999);
    drain();

    // Asynchronous reset in the middle of a game.
    rstn = 1'b0;
    #2;
    rstn = 1'b1;
    tick(1);
    press(5'h10);
    release_key();
    model_score = 0;
    for (int i = 0; i < 42; i++) hit_pulse(1);
    expect_val("score_0042", F_SCORE, 32'h0042);
    drain();
    #2;
    rstn = 1'b0;
    #1;
    expect_all("async_rst", 0, 1, 0, 3);
    drain();
    #10;
    rstn = 1'b1;
    tick(1);
    press(5'h10);
    expect_all("fresh_game", 1, 0, 0, 3);
    drain();
    release_key();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
